spu_result_pipe: RTL and testbench



---
 rtl/spu_result_pipe.sv | 190 +++++++++++++++++++
 tb/tb_spu_result_pipe.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_result_pipe.sv
// Result staging pipe for the even/odd SPU pipes: tracks issued instructions, captures results and drives writeback.
// Define SPU_RESULT_FWD_EN to forward ready in-flight results; otherwise any in-flight match raises a hazard.
module spu_result_pipe #(
    parameter int DEPTH = 8,
    parameter int DW    = 128,
    parameter int AW    = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          issue_valid_ep,
    input  logic          issue_valid_op,
    input  logic [AW-1:0] issue_rt_ep,
    input  logic [AW-1:0] issue_rt_op,
    input  logic [2:0]    issue_lat_ep,
    input  logic [2:0]    issue_lat_op,
    input  logic          res_valid_ep,
    input  logic          res_valid_op,
    input  logic [DW-1:0] res_data_ep,
    input  logic [DW-1:0] res_data_op,
    input  logic [AW-1:0] ra_addr_ep,
    input  logic [AW-1:0] rb_addr_ep,
    input  logic [AW-1:0] rc_addr_ep,
    input  logic [AW-1:0] ra_addr_op,
    input  logic [AW-1:0] rb_addr_op,
    input  logic [AW-1:0] rc_addr_op,
    input  logic [DW-1:0] rf_ra_ep,
    input  logic [DW-1:0] rf_rb_ep,
    input  logic [DW-1:0] rf_rc_ep,
    input  logic [DW-1:0] rf_ra_op,
    input  logic [DW-1:0] rf_rb_op,
    input  logic [DW-1:0] rf_rc_op,
    output logic [DW-1:0] opa_ep,
    output logic [DW-1:0] opb_ep,
    output logic [DW-1:0] opc_ep,
    output logic [DW-1:0] opa_op,
    output logic [DW-1:0] opb_op,
    output logic [DW-1:0] opc_op,
    output logic          hazard_ep,
    output logic          hazard_op,
    output logic          wrbe_ep,
    output logic          wrbe_op,
    output logic [AW-1:0] rt_addr_ep,
    output logic [AW-1:0] rt_addr_op,
    output logic [DW-1:0] rt_data_ep,
    output logic [DW-1:0] rt_data_op,
    output logic          proto_err
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rt;
        logic [2:0]    lat;
        logic          ready;
        logic [DW-1:0] data;
    } entry_t;

    // Index 0 is the even pipe, index 1 the odd pipe.
    entry_t         stage_q [2][1:DEPTH];
    logic           iss_valid [2];
    logic [AW-1:0]  iss_rt    [2];
    logic [2:0]     iss_lat   [2];
    logic           res_valid [2];
    logic [DW-1:0]  res_data  [2];
    logic [DEPTH:1] hit       [2];
    logic           err_now;

    logic [AW-1:0]  opnd_addr [6];
    logic [DW-1:0]  opnd_rf   [6];
    logic [DW-1:0]  opnd_val  [6];
    logic           opnd_haz  [6];

    assign iss_valid[0] = issue_valid_ep;
    assign iss_valid[1] = issue_valid_op;
    assign iss_rt[0]    = issue_rt_ep;
    assign iss_rt[1]    = issue_rt_op;
    assign iss_lat[0]   = issue_lat_ep;
    assign iss_lat[1]   = issue_lat_op;
    assign res_valid[0] = res_valid_ep;
    assign res_valid[1] = res_valid_op;
    assign res_data[0]  = res_data_ep;
    assign res_data[1]  = res_data_op;

    assign opnd_addr[0] = ra_addr_ep;
    assign opnd_addr[1] = rb_addr_ep;
    assign opnd_addr[2] = rc_addr_ep;
    assign opnd_addr[3] = ra_addr_op;
    assign opnd_addr[4] = rb_addr_op;
    assign opnd_addr[5] = rc_addr_op;
    assign opnd_rf[0]   = rf_ra_ep;
    assign opnd_rf[1]   = rf_rb_ep;
    assign opnd_rf[2]   = rf_rc_ep;
    assign opnd_rf[3]   = rf_ra_op;
    assign opnd_rf[4]   = rf_rb_op;
    assign opnd_rf[5]   = rf_rc_op;

    // Only legal latency stages can capture, so entries issued with a bad latency never become ready.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit[p] = '0;
            for (int k = 2; k <= DEPTH - 1; k++) begin
                hit[p][k] = stage_q[p][k].valid && (int'(stage_q[p][k].lat) == k);
            end
        end
    end

    always_comb begin
        err_now = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (iss_valid[p] && ((iss_lat[p] < 3'd2) || (int'(iss_lat[p]) > DEPTH - 1))) begin
                err_now = 1'b1;
            end
            if (res_valid[p] && (hit[p] == '0)) begin
                err_now = 1'b1;
            end
            if (stage_q[p][DEPTH].valid && !stage_q[p][DEPTH].ready) begin
                err_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 1; k <= DEPTH; k++) begin
                    stage_q[p][k] <= '0;
                end
            end
            proto_err <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                stage_q[p][1].valid <= iss_valid[p];
                stage_q[p][1].rt    <= iss_valid[p] ? iss_rt[p] : '0;
                stage_q[p][1].lat   <= iss_valid[p] ? iss_lat[p] : '0;
                stage_q[p][1].ready <= 1'b0;
                stage_q[p][1].data  <= '0;
                for (int k = 2; k <= DEPTH; k++) begin
                    stage_q[p][k] <= stage_q[p][k-1];
                    if (res_valid[p] && hit[p][k-1]) begin
                        stage_q[p][k].ready <= 1'b1;
                        stage_q[p][k].data  <= res_data[p];
                    end
                end
            end
            if (err_now) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Scan oldest to newest (odd after even within a stage) so the newest match overrides.
    always_comb begin
        for (int o = 0; o < 6; o++) begin
            opnd_val[o] = opnd_rf[o];
            opnd_haz[o] = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                for (int p = 0; p < 2; p++) begin
                    if (stage_q[p][k].valid && (stage_q[p][k].rt == opnd_addr[o])) begin
`ifdef SPU_RESULT_FWD_EN
                        if (stage_q[p][k].ready) begin
                            opnd_val[o] = stage_q[p][k].data;
                            opnd_haz[o] = 1'b0;
                        end else begin
                            opnd_haz[o] = 1'b1;
                        end
`else
                        opnd_haz[o] = 1'b1;
`endif
                    end
                end
            end
        end
    end

    assign opa_ep    = opnd_val[0];
    assign opb_ep    = opnd_val[1];
    assign opc_ep    = opnd_val[2];
    assign opa_op    = opnd_val[3];
    assign opb_op    = opnd_val[4];
    assign opc_op    = opnd_val[5];
    assign hazard_ep = opnd_haz[0] | opnd_haz[1] | opnd_haz[2];
    assign hazard_op = opnd_haz[3] | opnd_haz[4] | opnd_haz[5];

    assign wrbe_ep    = stage_q[0][DEPTH].valid & stage_q[0][DEPTH].ready;
    assign wrbe_op    = stage_q[1][DEPTH].valid & stage_q[1][DEPTH].ready;
    assign rt_addr_ep = stage_q[0][DEPTH].rt;
    assign rt_addr_op = stage_q[1][DEPTH].rt;
    assign rt_data_ep = stage_q[0][DEPTH].data;
    assign rt_data_op = stage_q[1][DEPTH].data;

endmodule

// File: tb/tb_spu_result_pipe.sv
// Bench for spu_result_pipe: directed scenarios and a randomized phase checked against
// a queue of in-flight instructions indexed by issue time.
module tb_spu_result_pipe;
    localparam int DEPTH = 8;
    localparam int DW    = 128;
    localparam int AW    = 7;
`ifdef SPU_RESULT_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          issue_valid_ep, issue_valid_op;
    logic [AW-1:0] issue_rt_ep, issue_rt_op;
    logic [2:0]    issue_lat_ep, issue_lat_op;
    logic          res_valid_ep, res_valid_op;
    logic [DW-1:0] res_data_ep, res_data_op;
    logic [AW-1:0] ra_addr_ep, rb_addr_ep, rc_addr_ep, ra_addr_op, rb_addr_op, rc_addr_op;
    logic [DW-1:0] rf_ra_ep, rf_rb_ep, rf_rc_ep, rf_ra_op, rf_rb_op, rf_rc_op;
    logic [DW-1:0] opa_ep, opb_ep, opc_ep, opa_op, opb_op, opc_op;
    logic          hazard_ep, hazard_op, wrbe_ep, wrbe_op, proto_err;
    logic [AW-1:0] rt_addr_ep, rt_addr_op;
    logic [DW-1:0] rt_data_ep, rt_data_op;

    spu_result_pipe #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .issue_valid_ep(issue_valid_ep), .issue_valid_op(issue_valid_op),
        .issue_rt_ep(issue_rt_ep), .issue_rt_op(issue_rt_op),
        .issue_lat_ep(issue_lat_ep), .issue_lat_op(issue_lat_op),
        .res_valid_ep(res_valid_ep), .res_valid_op(res_valid_op),
        .res_data_ep(res_data_ep), .res_data_op(res_data_op),
        .ra_addr_ep(ra_addr_ep), .rb_addr_ep(rb_addr_ep), .rc_addr_ep(rc_addr_ep),
        .ra_addr_op(ra_addr_op), .rb_addr_op(rb_addr_op), .rc_addr_op(rc_addr_op),
        .rf_ra_ep(rf_ra_ep), .rf_rb_ep(rf_rb_ep), .rf_rc_ep(rf_rc_ep),
        .rf_ra_op(rf_ra_op), .rf_rb_op(rf_rb_op), .rf_rc_op(rf_rc_op),
        .opa_ep(opa_ep), .opb_ep(opb_ep), .opc_ep(opc_ep),
        .opa_op(opa_op), .opb_op(opb_op), .opc_op(opc_op),
        .hazard_ep(hazard_ep), .hazard_op(hazard_op),
        .wrbe_ep(wrbe_ep), .wrbe_op(wrbe_op),
        .rt_addr_ep(rt_addr_ep), .rt_addr_op(rt_addr_op),
        .rt_data_ep(rt_data_ep), .rt_data_op(rt_data_op),
        .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            pipe;
        logic [AW-1:0] rt;
        int            lat;
        int            e0;
        logic [DW-1:0] plan;
        bit            drop;
        bit            has_res;
        logic [DW-1:0] data;
    } instr_t;

    instr_t        inflight[$];
    int            edge_cnt = 0;
    bit            exp_err  = 1'b0;
    logic [DW-1:0] plan_data [2];
    bit            plan_drop [2];
    int            tests = 0;
    int            fails = 0;

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int stageOf(input int e0);
        return edge_cnt - e0 + 1;
    endfunction

    // Lower rank is newer: younger stage first, odd before even within a stage.
    function automatic int rankOf(input int idx);
        return stageOf(inflight[idx].e0) * 2 + ((inflight[idx].pipe == 0) ? 1 : 0);
    endfunction

    function automatic bit legalLat(input int lat);
        return (lat >= 2) && (lat <= DEPTH - 1);
    endfunction

    function automatic void expectOperand(input logic [AW-1:0] a, input logic [DW-1:0] rf,
                                          output logic [DW-1:0] val, output logic haz);
        int best;
        val  = rf;
        haz  = 1'b0;
        best = 1 << 30;
        if (FWD) begin
            foreach (inflight[i]) begin
                if (inflight[i].rt == a && inflight[i].has_res && rankOf(i) < best) begin
                    best = rankOf(i);
                    val  = inflight[i].data;
                end
            end
            foreach (inflight[i]) begin
                if (inflight[i].rt == a && !inflight[i].has_res && rankOf(i) < best) haz = 1'b1;
            end
        end else begin
            foreach (inflight[i]) begin
                if (inflight[i].rt == a) haz = 1'b1;
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issueOn(input int p, input int rt, input int lat, input logic [DW-1:0] plan, input bit drop);
        if (p == 0) begin
            issue_valid_ep = 1'b1;
            issue_rt_ep    = AW'(rt);
            issue_lat_ep   = 3'(lat);
        end else begin
            issue_valid_op = 1'b1;
            issue_rt_op    = AW'(rt);
            issue_lat_op   = 3'(lat);
        end
        plan_data[p] = plan;
        plan_drop[p] = drop;
    endtask

    task automatic quietOperands();
        ra_addr_ep = 7'd120; rb_addr_ep = 7'd121; rc_addr_ep = 7'd122;
        ra_addr_op = 7'd123; rb_addr_op = 7'd124; rc_addr_op = 7'd125;
        rf_ra_ep = rand128(); rf_rb_ep = rand128(); rf_rc_ep = rand128();
        rf_ra_op = rand128(); rf_rb_op = rand128(); rf_rc_op = rand128();
    endtask

    task automatic randOperands();
        ra_addr_ep = AW'($urandom_range(0, 7)); rb_addr_ep = AW'($urandom_range(0, 7));
        rc_addr_ep = AW'($urandom_range(0, 7)); ra_addr_op = AW'($urandom_range(0, 7));
        rb_addr_op = AW'($urandom_range(0, 7)); rc_addr_op = AW'($urandom_range(0, 7));
        rf_ra_ep = rand128(); rf_rb_ep = rand128(); rf_rc_ep = rand128();
        rf_ra_op = rand128(); rf_rb_op = rand128(); rf_rc_op = rand128();
    endtask

    // Present each planned result in the cycle its instruction reaches its latency stage.
    task automatic autoResults();
        res_valid_ep = 1'b0;
        res_valid_op = 1'b0;
        foreach (inflight[i]) begin
            if (!inflight[i].drop && legalLat(inflight[i].lat) && stageOf(inflight[i].e0) == inflight[i].lat) begin
                if (inflight[i].pipe == 0) begin
                    res_valid_ep = 1'b1;
                    res_data_ep  = inflight[i].plan;
                end else begin
                    res_valid_op = 1'b1;
                    res_data_op  = inflight[i].plan;
                end
            end
        end
    endtask

    task automatic modelEdge();
        instr_t        keep[$];
        instr_t        n;
        bit            rv, iv, matched;
        logic [DW-1:0] rd;
        int            lat;
        if (reset) begin
            inflight.delete();
            exp_err = 1'b0;
            edge_cnt++;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rv = (p == 0) ? res_valid_ep : res_valid_op;
                rd = (p == 0) ? res_data_ep : res_data_op;
                if (rv) begin
                    matched = 1'b0;
                    foreach (inflight[i]) begin
                        if (inflight[i].pipe == p && legalLat(inflight[i].lat) &&
                            stageOf(inflight[i].e0) == inflight[i].lat) begin
                            inflight[i].has_res = 1'b1;
                            inflight[i].data    = rd;
                            matched             = 1'b1;
                        end
                    end
                    if (!matched) exp_err = 1'b1;
                end
            end
            foreach (inflight[i]) begin
                if (stageOf(inflight[i].e0) >= DEPTH) begin
                    if (!inflight[i].has_res) exp_err = 1'b1;
                end else begin
                    keep.push_back(inflight[i]);
                end
            end
            inflight = keep;
            edge_cnt++;
            for (int p = 0; p < 2; p++) begin
                iv  = (p == 0) ? issue_valid_ep : issue_valid_op;
                lat = (p == 0) ? int'(issue_lat_ep) : int'(issue_lat_op);
                if (iv) begin
                    if (!legalLat(lat)) exp_err = 1'b1;
                    n.pipe    = p;
                    n.rt      = (p == 0) ? issue_rt_ep : issue_rt_op;
                    n.lat     = lat;
                    n.e0      = edge_cnt;
                    n.plan    = plan_data[p];
                    n.drop    = plan_drop[p];
                    n.has_res = 1'b0;
                    n.data    = '0;
                    inflight.push_back(n);
                end
            end
        end
    endtask

    task automatic checkCycle();
        logic          wb [2];
        logic [AW-1:0] wa [2];
        logic [DW-1:0] wd [2];
        logic [DW-1:0] ev;
        logic          eh, hz_ep, hz_op;
        for (int p = 0; p < 2; p++) begin
            wb[p] = 1'b0; wa[p] = '0; wd[p] = '0;
        end
        foreach (inflight[i]) begin
            if (stageOf(inflight[i].e0) == DEPTH && inflight[i].has_res) begin
                wb[inflight[i].pipe] = 1'b1;
                wa[inflight[i].pipe] = inflight[i].rt;
                wd[inflight[i].pipe] = inflight[i].data;
            end
        end
        checkOutput("wrbe_ep", wrbe_ep, wb[0]);
        checkOutput("wrbe_op", wrbe_op, wb[1]);
        if (wb[0]) begin
            checkOutput("rt_addr_ep", rt_addr_ep, wa[0]);
            checkOutput("rt_data_ep", rt_data_ep, wd[0]);
        end
        if (wb[1]) begin
            checkOutput("rt_addr_op", rt_addr_op, wa[1]);
            checkOutput("rt_data_op", rt_data_op, wd[1]);
        end
        checkOutput("proto_err", proto_err, exp_err);
        expectOperand(ra_addr_ep, rf_ra_ep, ev, eh); checkOutput("opa_ep", opa_ep, ev); hz_ep = eh;
        expectOperand(rb_addr_ep, rf_rb_ep, ev, eh); checkOutput("opb_ep", opb_ep, ev); hz_ep |= eh;
        expectOperand(rc_addr_ep, rf_rc_ep, ev, eh); checkOutput("opc_ep", opc_ep, ev); hz_ep |= eh;
        expectOperand(ra_addr_op, rf_ra_op, ev, eh); checkOutput("opa_op", opa_op, ev); hz_op = eh;
        expectOperand(rb_addr_op, rf_rb_op, ev, eh); checkOutput("opb_op", opb_op, ev); hz_op |= eh;
        expectOperand(rc_addr_op, rf_rc_op, ev, eh); checkOutput("opc_op", opc_op, ev); hz_op |= eh;
        checkOutput("hazard_ep", hazard_ep, hz_ep);
        checkOutput("hazard_op", hazard_op, hz_op);
    endtask

    // One cycle: drive results, check this cycle's outputs, clock, update the model.
    task automatic applyStimulus();
        autoResults();
        #1;
        checkCycle();
        @(posedge clock);
        modelEdge();
        #1;
        issue_valid_ep = 1'b0;
        issue_valid_op = 1'b0;
        res_valid_ep   = 1'b0;
        res_valid_op   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        issue_valid_ep = 1'b0; issue_valid_op = 1'b0;
        issue_rt_ep = '0; issue_rt_op = '0; issue_lat_ep = '0; issue_lat_op = '0;
        res_valid_ep = 1'b0; res_valid_op = 1'b0; res_data_ep = '0; res_data_op = '0;
        plan_data[0] = '0; plan_data[1] = '0; plan_drop[0] = 1'b0; plan_drop[1] = 1'b0;
        quietOperands();
        @(posedge clock);
        modelEdge();
        #1;

        // Reset state
        checkOutput("reset_wrbe_ep", wrbe_ep, 1'b0);
        checkOutput("reset_wrbe_op", wrbe_op, 1'b0);
        checkOutput("reset_rt_addr_ep", rt_addr_ep, '0);
        checkOutput("reset_rt_data_op", rt_data_op, '0);
        checkOutput("reset_proto_err", proto_err, 1'b0);
        applyStimulus();
        reset = 1'b0;

        // Single writeback on the even pipe
        quietOperands();
        issueOn(0, 5, 2, {16{8'hAA}}, 1'b0);
        for (int c = 1; c <= 8; c++) applyStimulus();
        checkOutput("single_wrbe", wrbe_ep, 1'b1);
        checkOutput("single_rt_addr", rt_addr_ep, 7'd5);
        checkOutput("single_rt_data", rt_data_ep, {16{8'hAA}});
        applyStimulus();
        checkOutput("single_wrbe_done", wrbe_ep, 1'b0);
        checkOutput("single_no_err", proto_err, 1'b0);

        // Forward versus hazard
        quietOperands();
        ra_addr_ep = 7'd9;
        rf_ra_ep   = {4{32'hCAFE_F00D}};
        issueOn(1, 9, 4, 128'h1234, 1'b0);
        applyStimulus();
        for (int c = 1; c <= 9; c++) begin
            checkOutput("fwd_hazard_ep", hazard_ep, FWD ? (c <= 4) : (c <= 8));
            checkOutput("fwd_opa_ep", opa_ep, (FWD && c >= 5 && c <= 8) ? 128'h1234 : rf_ra_ep);
            applyStimulus();
        end

        // Same-stage priority
        quietOperands();
        ra_addr_op = 7'd3;
        issueOn(0, 3, 2, 128'h11, 1'b0);
        issueOn(1, 3, 2, 128'h22, 1'b0);
        applyStimulus();
        for (int c = 1; c <= 8; c++) begin
            if (c >= 3) checkOutput("prio_opa_op", opa_op, FWD ? 128'h22 : rf_ra_op);
            if (c == 8) begin
                checkOutput("prio_wrbe_ep", wrbe_ep, 1'b1);
                checkOutput("prio_wrbe_op", wrbe_op, 1'b1);
            end
            applyStimulus();
        end

        // Missing result, then illegal latency
        quietOperands();
        issueOn(0, 6, 3, '0, 1'b1);
        for (int c = 1; c <= 8; c++) applyStimulus();
        checkOutput("missing_no_wrbe", wrbe_ep, 1'b0);
        checkOutput("missing_err_c8", proto_err, 1'b0);
        applyStimulus();
        checkOutput("missing_err_c9", proto_err, 1'b1);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkOutput("err_cleared", proto_err, 1'b0);
        issueOn(0, 6, 1, '0, 1'b0);
        applyStimulus();
        checkOutput("badlat_err", proto_err, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;

        // Reset mid-flight
        quietOperands();
        issueOn(0, 10, 2, rand128(), 1'b0);
        issueOn(1, 11, 5, rand128(), 1'b0);
        applyStimulus();
        issueOn(0, 12, 3, rand128(), 1'b0);
        issueOn(1, 13, 7, rand128(), 1'b0);
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkOutput("rst_rt_addr_ep", rt_addr_ep, '0);
        checkOutput("rst_rt_data_ep", rt_data_ep, '0);
        checkOutput("rst_rt_addr_op", rt_addr_op, '0);
        checkOutput("rst_rt_data_op", rt_data_op, '0);
        for (int c = 0; c < 10; c++) begin
            checkOutput("rst_no_wrbe", wrbe_ep | wrbe_op, 1'b0);
            checkOutput("rst_no_err", proto_err, 1'b0);
            applyStimulus();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            randOperands();
            if ($urandom_range(0, 99) < 60) issueOn(0, $urandom_range(0, 7), $urandom_range(2, DEPTH - 1), rand128(), 1'b0);
            if ($urandom_range(0, 99) < 60) issueOn(1, $urandom_range(0, 7), $urandom_range(2, DEPTH - 1), rand128(), 1'b0);
            applyStimulus();
        end
        quietOperands();
        for (int c = 0; c <= DEPTH; c++) applyStimulus();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
